// File: rtl/coin_acceptor.sv
`default_nettype none
// coin_acceptor: synchronises and debounces the coin-slot sensor, measures pulse width,
// and presents classified coins as a one-hot code with an insert strobe or a reject pulse.
module coin_acceptor #(
  parameter int CNT_W    = 10,
  parameter int DEBOUNCE = 4,
  parameter int MIN_5    = 20,
  parameter int MAX_5    = 39,
  parameter int MIN_10   = 40,
  parameter int MAX_10   = 79,
  parameter int MIN_20   = 80,
  parameter int MAX_20   = 159,
  parameter int HOLD     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       enable,
  output logic [2:0] coins,
  output logic       insert,
  output logic       reject,
  output logic       busy
);

  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int HOLD_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEASURE = 3'd1,
    SETUP   = 3'd2,
    STROBE  = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              sync1, sync2, sdb, sdb_q;
  logic [DB_W-1:0]   db_cnt;
  logic [CNT_W-1:0]  width_cnt, width_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [2:0]        coin_q, coin_nxt, class_code;
  logic              lost, lost_nxt;
  logic              reject_q, reject_nxt;
  logic              sdb_rise, sdb_fall, hold_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sdb    <= 1'b0;
      sdb_q  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      sdb_q <= sdb;
      if (sync2 == sdb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
        sdb    <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign sdb_rise  = sdb & ~sdb_q;
  assign sdb_fall  = ~sdb & sdb_q;
  assign hold_done = (hold_cnt == HOLD_W'(HOLD - 1));

  // Window order gives 5c priority over 10c over 20c if windows ever overlap.
  always_comb begin
    class_code = 3'b000;
    if (width_cnt >= CNT_W'(MIN_5) && width_cnt <= CNT_W'(MAX_5))
      class_code = 3'b001;
    else if (width_cnt >= CNT_W'(MIN_10) && width_cnt <= CNT_W'(MAX_10))
      class_code = 3'b010;
    else if (width_cnt >= CNT_W'(MIN_20) && width_cnt <= CNT_W'(MAX_20))
      class_code = 3'b100;
  end

  always_comb begin
    state_nxt  = state;
    width_nxt  = width_cnt;
    hold_nxt   = hold_cnt;
    coin_nxt   = coin_q;
    lost_nxt   = lost;
    reject_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sdb_rise) begin
          state_nxt = MEASURE;
          width_nxt = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (sdb) begin
          if (width_cnt != CNT_MAX) width_nxt = width_cnt + 1'b1;
        end else if (class_code != 3'b000 && enable) begin
          state_nxt = SETUP;
          coin_nxt  = class_code;
        end else begin
          state_nxt  = RECOVER;
          hold_nxt   = '0;
          reject_nxt = 1'b1;
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        hold_nxt  = '0;
      end
      STROBE: begin
        if (hold_done) begin
          state_nxt = RECOVER;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      RECOVER: begin
        if (!hold_done) hold_nxt = hold_cnt + 1'b1;
        else if (!sdb) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A coin arriving while busy is never credited; it is returned at its fall.
    if (state == SETUP || state == STROBE || state == RECOVER) begin
      if (sdb_rise) begin
        lost_nxt = 1'b1;
      end else if (sdb_fall && lost) begin
        lost_nxt   = 1'b0;
        reject_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      width_cnt <= '0;
      hold_cnt  <= '0;
      coin_q    <= 3'b000;
      lost      <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      width_cnt <= width_nxt;
      hold_cnt  <= hold_nxt;
      coin_q    <= coin_nxt;
      lost      <= lost_nxt;
      reject_q  <= reject_nxt;
    end
  end

  assign coins  = (state == SETUP || state == STROBE) ? coin_q : 3'b000;
  assign insert = (state == STROBE);
  assign reject = reject_q;
  assign busy   = (state != IDLE);

endmodule
`default_nettype wire
